// File: rtl/spram_banked.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spram_banked
// Purpose  : single-port RAM with nibble write mask, 1/2-cycle read latency
//            and an OFF/SLEEP/STANDBY/WAKE/ACTIVE power state machine
// Revision : 1.0
// ============================================================================
module spram_banked #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 1,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [ADDR_WIDTH-1:0]   ADDRESS,
  input  logic [DATA_WIDTH-1:0]   DATAIN,
  input  logic [DATA_WIDTH/4-1:0] MASKWREN,
  input  logic                    WREN,
  input  logic                    CHIPSELECT,
  input  logic                    STANDBY,
  input  logic                    SLEEP,
  input  logic                    POWEROFF,
  output logic                    READY,
  output logic [DATA_WIDTH-1:0]   DATAOUT,
  output logic                    DATAVALID
);

  localparam int c_NIBBLES = DATA_WIDTH / 4;
  localparam int c_DEPTH   = 2 ** ADDR_WIDTH;

  localparam logic [2:0] c_ST_OFF     = 3'd0;
  localparam logic [2:0] c_ST_SLEEP   = 3'd1;
  localparam logic [2:0] c_ST_STANDBY = 3'd2;
  localparam logic [2:0] c_ST_WAKE    = 3'd3;
  localparam logic [2:0] c_ST_ACTIVE  = 3'd4;

  localparam logic [7:0] c_WAKE_LOAD = 8'(WAKE_CYCLES);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [7:0]            r_wake_cnt;
  logic [7:0]            w_wake_cnt_nxt;
  logic                  w_accept;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_flush;
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dv;

  assign READY     = (r_state == c_ST_ACTIVE);
  assign DATAOUT   = r_dout;
  assign DATAVALID = r_dv;

  assign w_accept = CHIPSELECT && READY;
  assign w_wr     = w_accept && WREN;
  assign w_rd     = w_accept && !WREN;
  // Entering SLEEP or OFF drops any reads still in the pipeline.
  assign w_flush  = (w_state_nxt == c_ST_OFF) || (w_state_nxt == c_ST_SLEEP);

  always_comb begin
    w_state_nxt    = r_state;
    w_wake_cnt_nxt = r_wake_cnt;
    if (!POWEROFF) begin
      w_state_nxt = c_ST_OFF;
    end else if (SLEEP) begin
      w_state_nxt = c_ST_SLEEP;
    end else if (STANDBY) begin
      w_state_nxt = c_ST_STANDBY;
    end else begin
      case (r_state)
        c_ST_OFF, c_ST_SLEEP: begin
          w_state_nxt    = c_ST_WAKE;
          w_wake_cnt_nxt = c_WAKE_LOAD;
        end
        c_ST_WAKE: begin
          if (r_wake_cnt <= 8'd1) begin
            w_state_nxt = c_ST_ACTIVE;
          end else begin
            w_wake_cnt_nxt = r_wake_cnt - 8'd1;
          end
        end
        default: w_state_nxt = c_ST_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state    <= c_ST_WAKE;
      r_wake_cnt <= c_WAKE_LOAD;
    end else begin
      r_state    <= w_state_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
    end
  end

  // Storage is deliberately not reset so contents survive RESET.
  always_ff @(posedge CLOCK) begin
    if (w_wr) begin
      for (int k = 0; k < c_NIBBLES; k++) begin
        if (MASKWREN[k]) begin
          r_mem[ADDRESS][4*k +: 4] <= DATAIN[4*k +: 4];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_s1_vld;
      logic [DATA_WIDTH-1:0] r_s1_dat;

      always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
          r_s1_vld <= 1'b0;
          r_s1_dat <= '0;
          r_dv     <= 1'b0;
          r_dout   <= '0;
        end else if (w_flush) begin
          r_s1_vld <= 1'b0;
          r_s1_dat <= '0;
          r_dv     <= 1'b0;
          r_dout   <= '0;
        end else begin
          r_s1_vld <= w_rd;
          if (w_rd) begin
            r_s1_dat <= r_mem[ADDRESS];
          end
          r_dv <= r_s1_vld;
          if (r_s1_vld) begin
            r_dout <= r_s1_dat;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
          r_dv   <= 1'b0;
          r_dout <= '0;
        end else if (w_flush) begin
          r_dv   <= 1'b0;
          r_dout <= '0;
        end else begin
          r_dv <= w_rd;
          if (w_rd) begin
            r_dout <= r_mem[ADDRESS];
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spram_banked.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for spram_banked: one latency-1 and one latency-2 instance share stimulus
// and are compared every cycle against a behavioural model.
module tb_spram_banked;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int WAKE = 4;
  localparam int M_OFF = 0, M_SLP = 1, M_STB = 2, M_WAKE = 3, M_ACT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cs, we, stby, slp, pwr;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW/4-1:0] mask;
  logic rdy1, dv1, rdy2, dv2;
  logic [DW-1:0] do1, do2;

  spram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WAKE_CYCLES(WAKE)) u_dut1 (
    .CLOCK(clk), .RESET(rst), .ADDRESS(addr), .DATAIN(din), .MASKWREN(mask), .WREN(we),
    .CHIPSELECT(cs), .STANDBY(stby), .SLEEP(slp), .POWEROFF(pwr),
    .READY(rdy1), .DATAOUT(do1), .DATAVALID(dv1));

  spram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WAKE_CYCLES(WAKE)) u_dut2 (
    .CLOCK(clk), .RESET(rst), .ADDRESS(addr), .DATAIN(din), .MASKWREN(mask), .WREN(we),
    .CHIPSELECT(cs), .STANDBY(stby), .SLEEP(slp), .POWEROFF(pwr),
    .READY(rdy2), .DATAOUT(do2), .DATAVALID(dv2));

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp,
                     input logic [DW-1:0] km);
    n_vec++;
    if (((act ^ exp) & km) !== '0) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (care bits %h) at %0t", nm, act, exp, km, $time);
    end
  endtask

  function automatic logic [DW-1:0] expand(input logic [DW/4-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < DW/4; k++) r[4*k +: 4] = {4{m[k]}};
    return r;
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct { int due; logic [DW-1:0] d; logic [DW-1:0] k; } rd_t;
  rd_t q1[$];
  rd_t q2[$];
  rd_t rr;
  logic [DW-1:0] mdat [int];
  logic [DW-1:0] mkn [int];
  int mode = M_WAKE;
  int wake_left = WAKE;
  int edge_no = 0;
  int nm;
  logic acc;
  logic [DW-1:0] rd, rk, em;
  logic ev1 = 1'b0, ev2 = 1'b0;
  logic [DW-1:0] eo1 = '0, eo2 = '0, ek1 = '1, ek2 = '1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = M_WAKE; wake_left = WAKE;
      q1.delete(); q2.delete();
      ev1 = 0; ev2 = 0; eo1 = '0; eo2 = '0; ek1 = '1; ek2 = '1;
    end else begin
      edge_no++;
      acc = cs && (mode == M_ACT);
      rd = mdat.exists(int'(addr)) ? mdat[int'(addr)] : '0;
      rk = mkn.exists(int'(addr)) ? mkn[int'(addr)] : '0;
      if (!pwr) nm = M_OFF;
      else if (slp) nm = M_SLP;
      else if (stby) nm = M_STB;
      else begin
        case (mode)
          M_OFF, M_SLP: begin nm = M_WAKE; wake_left = WAKE; end
          M_WAKE: if (wake_left == 1) nm = M_ACT; else begin nm = M_WAKE; wake_left--; end
          default: nm = M_ACT;
        endcase
      end
      if (acc && !we) begin
        q1.push_back('{edge_no, rd, rk});
        q2.push_back('{edge_no + 1, rd, rk});
      end
      ev1 = 0; ev2 = 0;
      if (q1.size() > 0 && q1[0].due == edge_no) begin
        rr = q1.pop_front(); ev1 = 1; eo1 = rr.d; ek1 = rr.k;
      end
      if (q2.size() > 0 && q2[0].due == edge_no) begin
        rr = q2.pop_front(); ev2 = 1; eo2 = rr.d; ek2 = rr.k;
      end
      if (nm == M_OFF || nm == M_SLP) begin
        q1.delete(); q2.delete();
        ev1 = 0; ev2 = 0; eo1 = '0; eo2 = '0; ek1 = '1; ek2 = '1;
      end
      if (acc && we) begin
        em = expand(mask);
        mdat[int'(addr)] = (rd & ~em) | (din & em);
        mkn[int'(addr)] = rk | em;
      end
      if (nm == M_OFF) begin mdat.delete(); mkn.delete(); end
      mode = nm;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready1", {31'd0, rdy1}, {31'd0, mode == M_ACT}, '1);
      chk("valid1", {31'd0, dv1}, {31'd0, ev1}, '1);
      chk("dout1", do1, eo1, ek1);
      chk("ready2", {31'd0, rdy2}, {31'd0, mode == M_ACT}, '1);
      chk("valid2", {31'd0, dv2}, {31'd0, ev2}, '1);
      chk("dout2", do2, eo2, ek2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic w, input int a, input logic [DW-1:0] d, input logic [DW/4-1:0] m);
    @(negedge clk);
    cs = 1'b1; we = w; addr = AW'(a); din = d; mask = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cs = 1'b0;
    end
  endtask

  task automatic wait_ready(input string nm_s, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy1 && n < 100);
    chk(nm_s, 32'(n), 32'(exp_n), '1);
  endtask

  typedef struct { logic w; int a; logic [DW-1:0] d; logic [7:0] m; logic ev; logic [DW-1:0] eo; } vec_t;
  localparam int NT = 13;
  vec_t tbl[NT];

  int pm_hold = 0;
  int pm_sel = 0;
  int r;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cs = 0; we = 0; stby = 0; slp = 0; pwr = 1;
    addr = '0; din = '0; mask = '0;
    tbl[0]  = '{1'b1, 'h10, 32'hDEADBEEF, 8'hFF, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 'h10, 32'h0,        8'h00, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 'h10, 32'h12345678, 8'h0F, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 'h10, 32'h0,        8'h00, 1'b1, 32'hDEAD5678};
    tbl[4]  = '{1'b1, 'h10, 32'hFFFFFFFF, 8'h00, 1'b0, 32'hDEAD5678};
    tbl[5]  = '{1'b0, 'h10, 32'h0,        8'h00, 1'b1, 32'hDEAD5678};
    tbl[6]  = '{1'b1, 'h20, 32'h00000000, 8'hFF, 1'b0, 32'hDEAD5678};
    tbl[7]  = '{1'b1, 'h20, 32'hA5A5A5A5, 8'hF0, 1'b0, 32'hDEAD5678};
    tbl[8]  = '{1'b0, 'h20, 32'h0,        8'h00, 1'b1, 32'hA5A50000};
    tbl[9]  = '{1'b1, 'h20, 32'h11111111, 8'h81, 1'b0, 32'hA5A50000};
    tbl[10] = '{1'b0, 'h20, 32'h0,        8'h00, 1'b1, 32'h15A50001};
    tbl[11] = '{1'b1, 'h20, 32'hCAFEF00D, 8'hFF, 1'b0, 32'h15A50001};
    tbl[12] = '{1'b0, 'h20, 32'h0,        8'h00, 1'b1, 32'hCAFEF00D};

    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_ready", {31'd0, rdy1}, 32'd0, '1);
    chk("reset_dout", do2, 32'd0, '1);
    rst = 1'b0;
    wait_ready("wake_after_reset", WAKE);

    // table-driven single-cycle accesses on the latency-1 instance
    for (int i = 0; i < NT; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("tbl%0d_valid", i-1), {31'd0, dv1}, {31'd0, tbl[i-1].ev}, '1);
        chk($sformatf("tbl%0d_dout", i-1), do1, tbl[i-1].eo, '1);
      end
      cs = 1'b1; we = tbl[i].w; addr = AW'(tbl[i].a); din = tbl[i].d; mask = tbl[i].m;
    end
    @(negedge clk);
    chk("tbl12_valid", {31'd0, dv1}, {31'd0, tbl[NT-1].ev}, '1);
    chk("tbl12_dout", do1, tbl[NT-1].eo, '1);
    cs = 1'b0;

    // latency-2 streaming of eight back-to-back reads
    for (int a = 0; a < 8; a++) drive(1'b1, a, 32'(a) * 32'h11111111, 8'hFF);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_valid", j), {31'd0, dv2}, {31'd0, (j >= 2 && j <= 9)}, '1);
      if (j >= 2 && j <= 9) chk($sformatf("stream%0d_dout", j), do2, 32'(j-2) * 32'h11111111, '1);
      cs = (j < 8); we = 1'b0; addr = AW'(j);
    end
    idle(1);

    // sleep while a latency-2 read is in flight
    drive(1'b0, 'h10, '0, '0);
    @(negedge clk); cs = 1'b0; slp = 1'b1;
    @(negedge clk);
    chk("sleep_valid2", {31'd0, dv2}, 32'd0, '1);
    chk("sleep_dout2", do2, 32'd0, '1);
    chk("sleep_ready", {31'd0, rdy1}, 32'd0, '1);
    idle(3);
    chk("sleep_dout1", do1, 32'd0, '1);
    slp = 1'b0;
    wait_ready("wake_after_sleep", 1 + WAKE);
    drive(1'b0, 'h10, '0, '0);
    @(negedge clk); cs = 1'b0;
    chk("sleep_keep1", do1, 32'hDEAD5678, '1);
    @(negedge clk);
    chk("sleep_keep2", do2, 32'hDEAD5678, '1);

    // standby: in-flight read completes, writes during standby are ignored
    drive(1'b0, 3, '0, '0);
    @(negedge clk); cs = 1'b0; stby = 1'b1;
    @(negedge clk);
    chk("stby_valid2", {31'd0, dv2}, 32'd1, '1);
    chk("stby_dout2", do2, 32'h33333333, '1);
    chk("stby_ready", {31'd0, rdy1}, 32'd0, '1);
    cs = 1'b1; we = 1'b1; addr = AW'(3); din = '0; mask = 8'hFF;
    @(negedge clk);
    @(negedge clk); cs = 1'b0; stby = 1'b0;
    wait_ready("wake_after_stby", 1);
    drive(1'b0, 3, '0, '0);
    @(negedge clk); cs = 1'b0;
    chk("stby_keep", do1, 32'h33333333, '1);

    // power removal and restore
    @(negedge clk); pwr = 1'b0;
    idle(3);
    chk("off_dout1", do1, 32'd0, '1);
    chk("off_ready", {31'd0, rdy1}, 32'd0, '1);
    pwr = 1'b1;
    wait_ready("wake_after_off", 1 + WAKE);
    drive(1'b1, 5, 32'h5A5A0F0F, 8'hFF);
    drive(1'b0, 5, '0, '0);

    // asynchronous reset with a latency-2 read in flight
    @(posedge clk);
    #2; rst = 1'b1; cs = 1'b0;
    #1;
    chk("arst_valid1", {31'd0, dv1}, 32'd0, '1);
    chk("arst_dout1", do1, 32'd0, '1);
    chk("arst_valid2", {31'd0, dv2}, 32'd0, '1);
    chk("arst_ready", {31'd0, rdy1}, 32'd0, '1);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    wait_ready("wake_after_reset2", WAKE);

    // randomized traffic with occasional power-mode excursions
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (pm_hold == 0) begin
        r = int'($urandom_range(0, 99));
        pm_sel = (r < 70) ? 0 : (r < 82) ? 1 : (r < 92) ? 2 : 3;
        pm_hold = int'($urandom_range(1, 8));
      end
      pm_hold--;
      stby = (pm_sel == 1);
      slp  = (pm_sel == 2);
      pwr  = (pm_sel != 3);
      cs   = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1) == 1;
      addr = AW'($urandom_range(0, 15));
      din  = $urandom;
      mask = 8'($urandom);
    end
    @(negedge clk);
    cs = 1'b0; stby = 1'b0; slp = 1'b0; pwr = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
